// File: rtl/fetch_mem_arbiter.sv
// fetch_mem_arbiter: shares one single-port memory between an instruction
// fetch requester and a data load/store requester. Data (MEM) wins ties,
// accesses are never preempted, and a pending requester is granted straight
// out of the other's completion edge so the port carries no idle bubble.
// Optional stall statistics are built only when ARB_STATS_EN is defined.
module fetch_mem_arbiter #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    output logic        port_en,
    output logic        port_we,
    output logic [31:0] port_addr,
    output logic [31:0] port_wdata,
    input  logic [31:0] port_rdata,
    output logic        if_stall,
    output logic        mem_stall,
    output logic [15:0] if_stall_cnt,
    output logic [15:0] mem_stall_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_ACC  = 2'd1,
        MEM_ACC = 2'd2
    } state_e;

    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;
    logic        if_ready_q, if_ready_d;
    logic        mem_ready_q, mem_ready_d;
    logic        port_en_q, port_en_d;
    logic        port_we_q, port_we_d;
    logic [31:0] port_addr_q, port_addr_d;
    logic [31:0] port_wdata_q, port_wdata_d;

    logic        if_pend;
    logic        mem_pend;
    logic        acc_done;

    // A requester whose ready pulse is showing this cycle is already served
    assign if_pend  = if_req & ~if_ready_q;
    assign mem_pend = (mem_rd | mem_wr) & ~mem_ready_q;
    assign acc_done = (cnt_q == LAST_CNT);

    // Arbitration, access sequencing and read-data capture
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        if_rdata_d   = if_rdata_q;
        mem_rdata_d  = mem_rdata_q;
        if_ready_d   = 1'b0;
        mem_ready_d  = 1'b0;
        port_en_d    = port_en_q;
        port_we_d    = port_we_q;
        port_addr_d  = port_addr_q;
        port_wdata_d = port_wdata_q;

        unique case (state_q)
            IDLE: begin
                if (mem_pend) begin
                    state_d      = MEM_ACC;
                    cnt_d        = '0;
                    port_en_d    = 1'b1;
                    port_we_d    = mem_wr;
                    port_addr_d  = mem_addr;
                    port_wdata_d = mem_wdata;
                end else if (if_pend) begin
                    state_d      = IF_ACC;
                    cnt_d        = '0;
                    port_en_d    = 1'b1;
                    port_we_d    = 1'b0;
                    port_addr_d  = if_addr;
                    port_wdata_d = '0;
                end
            end

            IF_ACC: begin
                if (acc_done) begin
                    if_rdata_d = port_rdata;
                    if_ready_d = 1'b1;
                    cnt_d      = '0;
                    // hand the port straight to a waiting data access
                    if (mem_pend) begin
                        state_d      = MEM_ACC;
                        port_en_d    = 1'b1;
                        port_we_d    = mem_wr;
                        port_addr_d  = mem_addr;
                        port_wdata_d = mem_wdata;
                    end else begin
                        state_d      = IDLE;
                        port_en_d    = 1'b0;
                        port_we_d    = 1'b0;
                        port_addr_d  = '0;
                        port_wdata_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            MEM_ACC: begin
                if (acc_done) begin
                    if (!port_we_q) begin
                        mem_rdata_d = port_rdata;
                    end
                    mem_ready_d = 1'b1;
                    cnt_d       = '0;
                    // hand the port straight to a waiting fetch
                    if (if_pend) begin
                        state_d      = IF_ACC;
                        port_en_d    = 1'b1;
                        port_we_d    = 1'b0;
                        port_addr_d  = if_addr;
                        port_wdata_d = '0;
                    end else begin
                        state_d      = IDLE;
                        port_en_d    = 1'b0;
                        port_we_d    = 1'b0;
                        port_addr_d  = '0;
                        port_wdata_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            default: begin
                state_d      = IDLE;
                cnt_d        = '0;
                port_en_d    = 1'b0;
                port_we_d    = 1'b0;
                port_addr_d  = '0;
                port_wdata_d = '0;
            end
        endcase
    end

    // State, counter, data and port registers; reset clears everything at once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            if_rdata_q   <= '0;
            mem_rdata_q  <= '0;
            if_ready_q   <= 1'b0;
            mem_ready_q  <= 1'b0;
            port_en_q    <= 1'b0;
            port_we_q    <= 1'b0;
            port_addr_q  <= '0;
            port_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            if_rdata_q   <= if_rdata_d;
            mem_rdata_q  <= mem_rdata_d;
            if_ready_q   <= if_ready_d;
            mem_ready_q  <= mem_ready_d;
            port_en_q    <= port_en_d;
            port_we_q    <= port_we_d;
            port_addr_q  <= port_addr_d;
            port_wdata_q <= port_wdata_d;
        end
    end

    assign if_rdata   = if_rdata_q;
    assign if_ready   = if_ready_q;
    assign mem_rdata  = mem_rdata_q;
    assign mem_ready  = mem_ready_q;
    assign port_en    = port_en_q;
    assign port_we    = port_we_q;
    assign port_addr  = port_addr_q;
    assign port_wdata = port_wdata_q;

    assign if_stall   = if_req & ~if_ready_q;
    assign mem_stall  = (mem_rd | mem_wr) & ~mem_ready_q;

`ifdef ARB_STATS_EN
    logic [15:0] if_stall_cnt_q, if_stall_cnt_d;
    logic [15:0] mem_stall_cnt_q, mem_stall_cnt_d;

    // Saturating stall-cycle counters
    always_comb begin
        if_stall_cnt_d  = if_stall_cnt_q;
        mem_stall_cnt_d = mem_stall_cnt_q;
        if (if_stall && (if_stall_cnt_q != '1)) begin
            if_stall_cnt_d = if_stall_cnt_q + 16'd1;
        end
        if (mem_stall && (mem_stall_cnt_q != '1)) begin
            mem_stall_cnt_d = mem_stall_cnt_q + 16'd1;
        end
    end

    // Stall counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_stall_cnt_q  <= '0;
            mem_stall_cnt_q <= '0;
        end else begin
            if_stall_cnt_q  <= if_stall_cnt_d;
            mem_stall_cnt_q <= mem_stall_cnt_d;
        end
    end

    assign if_stall_cnt  = if_stall_cnt_q;
    assign mem_stall_cnt = mem_stall_cnt_q;
`else
    assign if_stall_cnt  = '0;
    assign mem_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_mem_arbiter.sv
// Scoreboard bench for fetch_mem_arbiter (WAIT_CYCLES=2). Stimulus pushes
// expected ready pulses and per-cycle port values; a negedge monitor pops
// and compares them as the DUT presents them.
module tb_fetch_mem_arbiter;

    localparam int unsigned WC = 2;

`ifdef ARB_STATS_EN
    localparam logic [15:0] EXP_IF_STALL_A = 16'd4;
    localparam logic [15:0] EXP_SAT        = 16'hFFFF;
`else
    localparam logic [15:0] EXP_IF_STALL_A = 16'd0;
    localparam logic [15:0] EXP_SAT        = 16'd0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        port_en;
    logic        port_we;
    logic [31:0] port_addr;
    logic [31:0] port_wdata;
    logic [31:0] port_rdata;
    logic        if_stall;
    logic        mem_stall;
    logic [15:0] if_stall_cnt;
    logic [15:0] mem_stall_cnt;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    fetch_mem_arbiter #(.WAIT_CYCLES(WC)) dut (
        .clk           (clk),
        .rst           (rst),
        .if_req        (if_req),
        .if_addr       (if_addr),
        .if_rdata      (if_rdata),
        .if_ready      (if_ready),
        .mem_rd        (mem_rd),
        .mem_wr        (mem_wr),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .mem_ready     (mem_ready),
        .port_en       (port_en),
        .port_we       (port_we),
        .port_addr     (port_addr),
        .port_wdata    (port_wdata),
        .port_rdata    (port_rdata),
        .if_stall      (if_stall),
        .mem_stall     (mem_stall),
        .if_stall_cnt  (if_stall_cnt),
        .mem_stall_cnt (mem_stall_cnt)
    );

    // Memory contents seen on the port
    always_comb begin
        case (port_addr)
            32'h0000_0010: port_rdata = 32'hE3A0_1005;
            32'h0000_0020: port_rdata = 32'hCAFE_F00D;
            32'h0000_0200: port_rdata = 32'h1234_5678;
            default:       port_rdata = port_addr ^ 32'hA5A5_A5A5;
        endcase
    end

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } rdy_t;

    typedef struct {
        int          cyc;
        logic        en;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } port_t;

    rdy_t  if_q[$];
    rdy_t  mem_q[$];
    port_t port_q[$];

    int checks = 0;
    int passed = 0;
    bit sb_on  = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: compares DUT responses against queued expectations
    always @(negedge clk) begin
        rdy_t  r;
        port_t p;
        if (sb_on) begin
            if (if_ready) begin
                if (if_q.size() == 0) chk("if_ready_unexpected", 32'(if_ready), 32'd0);
                else begin
                    r = if_q.pop_front();
                    chk("if_ready_cycle", cyc, r.cyc);
                    chk("if_rdata", if_rdata, r.data);
                end
            end
            if (mem_ready) begin
                if (mem_q.size() == 0) chk("mem_ready_unexpected", 32'(mem_ready), 32'd0);
                else begin
                    r = mem_q.pop_front();
                    chk("mem_ready_cycle", cyc, r.cyc);
                    chk("mem_rdata", mem_rdata, r.data);
                end
            end
            if (port_q.size() > 0 && port_q[0].cyc == cyc) begin
                p = port_q.pop_front();
                chk("port_en", 32'(port_en), 32'(p.en));
                chk("port_we", 32'(port_we), 32'(p.we));
                chk("port_addr", port_addr, p.addr);
                chk("port_wdata", port_wdata, p.wdata);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_port(input int c, input logic en, input logic we,
                             input logic [31:0] a, input logic [31:0] w);
        port_t p;
        p.cyc = c; p.en = en; p.we = we; p.addr = a; p.wdata = w;
        port_q.push_back(p);
    endtask

    task automatic push_acc(input int first, input logic we,
                            input logic [31:0] a, input logic [31:0] w);
        for (int k = 0; k <= int'(WC); k++) push_port(first + k, 1'b1, we, a, w);
    endtask

    task automatic push_rdy(input bit is_if, input int c, input logic [31:0] d);
        rdy_t r;
        r.cyc = c; r.data = d;
        if (is_if) if_q.push_back(r);
        else mem_q.push_back(r);
    endtask

    task automatic wait_if(input int limit);
        int n = 0;
        while (!if_ready && n < limit) begin @(negedge clk); n++; end
        if (!if_ready) begin
            checks++;
            $display("FAIL if_ready_timeout: no pulse within %0d cycles", limit);
        end
    endtask

    task automatic wait_mem(input int limit);
        int n = 0;
        while (!mem_ready && n < limit) begin @(negedge clk); n++; end
        if (!mem_ready) begin
            checks++;
            $display("FAIL mem_ready_timeout: no pulse within %0d cycles", limit);
        end
    endtask

    // Drops each request on its ready pulse; bounded
    task automatic serve_both(input int limit, input int t_probe);
        int n = 0;
        while ((if_req || mem_rd || mem_wr) && n < limit) begin
            @(negedge clk);
            n++;
            if (cyc == t_probe) begin
                chk("if_stall_probe", 32'(if_stall), 32'd1);
                chk("mem_stall_probe", 32'(mem_stall), 32'd0);
            end
            if (mem_ready) begin mem_rd = 1'b0; mem_wr = 1'b0; end
            if (if_ready) if_req = 1'b0;
        end
        if (if_req || mem_rd || mem_wr) begin
            checks++;
            $display("FAIL serve_timeout: requests still pending after %0d cycles", limit);
        end
    endtask

    initial begin
        int  t0;
        bit  seen;
        rst = 1'b0; if_req = 1'b0; if_addr = '0;
        mem_rd = 1'b0; mem_wr = 1'b0; mem_addr = '0; mem_wdata = '0;

        // reset state
        step(2);
        chk("rst_port_en", 32'(port_en), 32'd0);
        chk("rst_port_addr", port_addr, 32'd0);
        chk("rst_if_ready", 32'(if_ready), 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_mem_rdata", mem_rdata, 32'd0);
        chk("rst_if_stall_cnt", 32'(if_stall_cnt), 32'd0);
        rst = 1'b1;
        step(2);

        // single fetch from an idle arbiter
        t0 = cyc;
        if_req = 1'b1; if_addr = 32'h10;
        push_acc(t0 + 1, 1'b0, 32'h10, 32'h0);
        push_port(t0 + 4, 1'b0, 1'b0, 32'h0, 32'h0);
        push_rdy(1'b1, t0 + 4, 32'hE3A0_1005);
        step(1);
        wait_if(20);
        if_req = 1'b0;
        step(3);
        chk("if_stall_cnt_single", 32'(if_stall_cnt), 32'(EXP_IF_STALL_A));
        chk("mem_stall_cnt_single", 32'(mem_stall_cnt), 32'd0);

        // simultaneous fetch and load: data first, fetch follows without a bubble
        t0 = cyc;
        if_req = 1'b1; if_addr = 32'h20;
        mem_rd = 1'b1; mem_addr = 32'h200; mem_wdata = 32'h0;
        push_acc(t0 + 1, 1'b0, 32'h200, 32'h0);
        push_acc(t0 + 4, 1'b0, 32'h20, 32'h0);
        push_port(t0 + 7, 1'b0, 1'b0, 32'h0, 32'h0);
        push_rdy(1'b0, t0 + 4, 32'h1234_5678);
        push_rdy(1'b1, t0 + 7, 32'hCAFE_F00D);
        serve_both(30, t0 + 5);
        step(3);

        // store: read data register must keep the earlier load value
        t0 = cyc;
        mem_wr = 1'b1; mem_addr = 32'h400; mem_wdata = 32'hDEAD_BEEF;
        push_acc(t0 + 1, 1'b1, 32'h400, 32'hDEAD_BEEF);
        push_port(t0 + 4, 1'b0, 1'b0, 32'h0, 32'h0);
        push_rdy(1'b0, t0 + 4, 32'h1234_5678);
        step(1);
        wait_mem(20);
        mem_wr = 1'b0; mem_wdata = 32'h0;
        step(3);

        // fetch raised mid-load waits for the load to finish
        t0 = cyc;
        mem_rd = 1'b1; mem_addr = 32'h30;
        push_acc(t0 + 1, 1'b0, 32'h30, 32'h0);
        push_rdy(1'b0, t0 + 4, 32'hA5A5_A595);
        step(1);
        if_req = 1'b1; if_addr = 32'h10;
        push_acc(t0 + 4, 1'b0, 32'h10, 32'h0);
        push_port(t0 + 7, 1'b0, 1'b0, 32'h0, 32'h0);
        push_rdy(1'b1, t0 + 7, 32'hE3A0_1005);
        serve_both(30, t0 + 5);
        step(3);

        // reset in the middle of a fetch (cnt==1)
        t0 = cyc;
        if_req = 1'b1; if_addr = 32'h20;
        step(2);
        rst = 1'b0;
        #1;
        chk("midrst_port_en", 32'(port_en), 32'd0);
        chk("midrst_port_addr", port_addr, 32'd0);
        chk("midrst_if_rdata", if_rdata, 32'd0);
        chk("midrst_mem_rdata", mem_rdata, 32'd0);
        chk("midrst_if_stall_cnt", 32'(if_stall_cnt), 32'd0);
        if_req = 1'b0;
        step(2);
        rst = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (if_ready) seen = 1'b1;
        end
        chk("no_ready_after_reset", 32'(seen), 32'd0);

        // fetch after reset release completes normally
        t0 = cyc;
        if_req = 1'b1; if_addr = 32'h10;
        push_acc(t0 + 1, 1'b0, 32'h10, 32'h0);
        push_port(t0 + 4, 1'b0, 1'b0, 32'h0, 32'h0);
        push_rdy(1'b1, t0 + 4, 32'hE3A0_1005);
        step(1);
        wait_if(20);
        if_req = 1'b0;
        step(5);
        chk("if_rdata_hold", if_rdata, 32'hE3A0_1005);
        chk("sb_drained", 32'(if_q.size() + mem_q.size() + port_q.size()), 32'd0);

        // long contention for the stall statistics
        sb_on = 1'b0;
        if_req = 1'b1; if_addr = 32'h40;
        mem_rd = 1'b1; mem_addr = 32'h80;
        repeat (80000) @(negedge clk);
        chk("if_stall_cnt_sat", 32'(if_stall_cnt), 32'(EXP_SAT));
        chk("mem_stall_cnt_sat", 32'(mem_stall_cnt), 32'(EXP_SAT));
        if_req = 1'b0; mem_rd = 1'b0;
        step(6);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/fetch_mem_arbiter.md
FETCH_MEM_ARBITER -- requirements
Module: fetch_mem_arbiter

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, extra memory cycles per access (access length = WAIT_CYCLES+1 cycles, legal range 0..15).
REQ-002 clk  in  1  single clock, all state updates on posedge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 if_req  in  1  instruction-fetch read request, held until if_ready.
REQ-005 if_addr  in  32  fetch address (PC).
REQ-006 if_rdata  out  32  fetched instruction, registered.
REQ-007 if_ready  out  1  one-cycle pulse, if_rdata valid.
REQ-008 mem_rd, mem_wr  in  1 each  data read/write request, held until mem_ready; never both high.
REQ-009 mem_addr, mem_wdata  in  32 each  data address / write data.
REQ-010 mem_rdata  out  32  read data, registered; mem_ready  out  1  one-cycle completion pulse (reads and writes).
REQ-011 port_en, port_we  out  1 each; port_addr, port_wdata  out  32 each  shared single-port memory drive.
REQ-012 port_rdata  in  32  memory read data, valid in last access cycle.
REQ-013 if_stall  out  1  = if_req & ~if_ready, drives IF stage register freeze; mem_stall  out  1  = (mem_rd|mem_wr) & ~mem_ready.
REQ-014 if_stall_cnt, mem_stall_cnt  out  16 each  stall statistics (see Configuration).

Function
REQ-015 FSM states IDLE, IF_ACC, MEM_ACC; 4-bit cycle counter cnt.
REQ-016 Grant decision at a posedge from IDLE: MEM request wins over IF when both pending; chosen ACC entered with cnt=0.
REQ-017 In IF_ACC/MEM_ACC: port_en=1, port_addr/port_we/port_wdata from the granted requester, held stable whole access; port_we=0 for IF.
REQ-018 In IDLE: port_en=0, port_we=0, port_addr/port_wdata=0.
REQ-019 cnt increments each ACC cycle; access completes at posedge with cnt==WAIT_CYCLES.
REQ-020 At completion edge: port_rdata captured into if_rdata (IF) or mem_rdata (MEM reads only; writes leave mem_rdata unchanged); matching ready pulses high next cycle.
REQ-021 At completion edge the other requester, if pending, is granted directly (no IDLE bubble); completing requester excluded; else IDLE.
REQ-022 Request whose ready is high in the current cycle is ignored for arbitration.
REQ-023 Latency, idle arbiter: request raised in cycle 0 -> ready in cycle WAIT_CYCLES+2.
REQ-024 No preemption: request arriving mid-access waits until completion.
REQ-025 Requests dropped mid-access: access still completes, ready still pulses (requester ignores it).
REQ-026 if_rdata/mem_rdata hold value until next capture.

Reset
REQ-027 rst low: state IDLE, cnt=0, if_ready=mem_ready=0, if_rdata=mem_rdata=0, port outputs 0, stall counters 0, immediately regardless of clk.
REQ-028 Reset mid-access aborts it; no ready pulse issued after release; first grant earliest at first posedge after rst high.

Configuration
REQ-029 Macro ARB_STATS_EN defined: if_stall_cnt/mem_stall_cnt increment each cycle if_stall/mem_stall high, saturate at 16'hFFFF.
REQ-030 ARB_STATS_EN undefined: counters not built, both outputs constant 0; all other behaviour identical.

Verification (WAIT_CYCLES=2)
REQ-031 if_req=1, addr 0x10, port_rdata=0xE3A01005 in access -> port_en cycles 1-3, if_ready+if_rdata=0xE3A01005 cycle 4.
REQ-032 if_req and mem_rd raised same cycle -> MEM_ACC first (mem_ready cycle 4), IF_ACC cycles 4-6, if_ready cycle 7, port_en continuous cycles 1-6.
REQ-033 mem_wr addr 0x400 wdata 0xDEADBEEF -> port_we=1 three cycles with those values; mem_ready pulse; mem_rdata unchanged.
REQ-034 rst low during IF_ACC cnt=1 -> all outputs 0 at once; no if_ready after release; re-request completes normally.
REQ-035 ARB_STATS_EN defined, 70000 cycles of blocked IF -> if_stall_cnt=0xFFFF; undefined -> 0.
